// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encodings, default widths, response record and issue-slot states.
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_sel_e;

  typedef enum logic {
    ISS_IDLE = 1'b0,
    ISS_BUSY = 1'b1
  } iss_state_e;

  typedef struct packed {
    logic [ALU_XLEN-1:0]  result;
    logic                 zero;
    logic [ALU_TAG_W-1:0] rd;
  } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Two-entry in-order response buffer with valid/ready output and an occupancy count.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter type entry_t = rsp_t
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       push,
  input  entry_t     push_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output entry_t     rsp_data,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   pop;

  assign rsp_valid = (count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = mem[rd_ptr];

  // The producer never pushes into a full buffer; req_ready reserves the slot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the combinational ALU; responses leave through alu_rsp_fifo.
// Define ALU_BYPASS_EN to forward the in-flight result into a dependent back-to-back request.
//
// state    | meaning
// ISS_IDLE | issue slot empty, alu_* hold the last issued operands
// ISS_BUSY | issue slot holds an op whose ALU result is captured at the next edge
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic [XLEN-1:0]  req_op1,
  input  logic [XLEN-1:0]  req_op2,
  input  logic [TAG_W-1:0] req_rs1,
  input  logic [TAG_W-1:0] req_rs2,
  input  logic [TAG_W-1:0] req_rd,
  output logic [XLEN-1:0]  alu_data1,
  output logic [XLEN-1:0]  alu_data2,
  output logic [2:0]       alu_select,
  output logic             alu_rotate,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_rd
);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic             zero;
    logic [TAG_W-1:0] rd;
  } entry_t;

  iss_state_e       state_q, state_d;
  logic             iss_valid;
  logic [XLEN-1:0]  iss_data1, iss_data2;
  logic [2:0]       iss_sel;
  logic             iss_rot;
  logic [TAG_W-1:0] iss_rd;
  logic [XLEN-1:0]  op1_d, op2_d;
  logic             accept;
  logic [1:0]       count;
  entry_t           push_data;
  entry_t           head;

  assign iss_valid = (state_q == ISS_BUSY);
  // Reserve a buffer slot for the in-flight op without looking at rsp_ready.
  assign req_ready = (count + {1'b0, iss_valid}) < 2'd2;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISS_IDLE: if (accept) state_d = ISS_BUSY;
      ISS_BUSY: state_d = accept ? ISS_BUSY : ISS_IDLE;
      default:  state_d = ISS_IDLE;
    endcase
  end

`ifdef ALU_BYPASS_EN
  logic fwd1, fwd2;
  always_comb begin
    fwd1  = iss_valid && (iss_rd != '0) && (req_rs1 == iss_rd);
    fwd2  = iss_valid && (iss_rd != '0) && (req_rs2 == iss_rd);
    op1_d = fwd1 ? alu_result : req_op1;
    op2_d = fwd2 ? alu_result : req_op2;
  end
`else
  logic unused_rs;
  assign unused_rs = ^{req_rs1, req_rs2};
  always_comb begin
    op1_d = req_op1;
    op2_d = req_op2;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ISS_IDLE;
      iss_data1 <= '0;
      iss_data2 <= '0;
      iss_sel   <= ALU_ADD;
      iss_rot   <= 1'b0;
      iss_rd    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        iss_data1 <= op1_d;
        iss_data2 <= op2_d;
        iss_sel   <= req_funct3;
        iss_rot   <= req_funct7b5;
        iss_rd    <= req_rd;
      end
    end
  end

  assign alu_data1  = iss_data1;
  assign alu_data2  = iss_data2;
  assign alu_select = iss_sel;
  assign alu_rotate = iss_rot;

  assign push_data = '{result: alu_result, zero: alu_zero, rd: iss_rd};

  alu_rsp_fifo #(.entry_t(entry_t)) u_rsp_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (iss_valid),
    .push_data (push_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (head),
    .count     (count)
  );

  assign rsp_result = head.result;
  assign rsp_zero   = head.zero;
  assign rsp_rd     = head.rd;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the operand/result loop.
module tb_alu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic [31:0] req_op1, req_op2;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [2:0]  alu_select;
  logic        alu_rotate, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_rd;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  alu_issue_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_op1(req_op1), .req_op2(req_op2),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_select(alu_select), .alu_rotate(alu_rotate),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_rd(rsp_rd)
  );

  // Behavioural stand-in for the combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_select)
      3'b000: alu_result = alu_rotate ? alu_data1 - alu_data2 : alu_data1 + alu_data2;
      3'b001: alu_result = alu_data1 << alu_data2[4:0];
      3'b010: alu_result = {31'b0, $signed(alu_data1) < $signed(alu_data2)};
      3'b011: alu_result = {31'b0, alu_data1 < alu_data2};
      3'b100: alu_result = alu_data1 ^ alu_data2;
      3'b101: alu_result = alu_rotate ? 32'($signed(alu_data1) >>> alu_data2[4:0])
                                      : alu_data1 >> alu_data2[4:0];
      3'b110: alu_result = alu_data1 | alu_data2;
      default: alu_result = alu_data1 & alu_data2;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    req_valid = 1'b1; req_funct3 = f3; req_funct7b5 = f7;
    req_op1 = a; req_op2 = b; req_rs1 = s1; req_rs2 = s2; req_rd = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_op1 = '0; req_op2 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; rsp_ready = 1'b1;
    #12;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b want=0", rsp_valid); end
    total++; if ({alu_data1, alu_data2} !== 64'd0) begin bad++; $display("FAIL rst_alu_data got=%0h/%0h want=0/0", alu_data1, alu_data2); end
    total++; if ({alu_select, alu_rotate} !== 4'd0) begin bad++; $display("FAIL rst_alu_ctrl got=%0b/%0b want=0/0", alu_select, alu_rotate); end
    total++; if ({rsp_result, rsp_zero, rsp_rd} !== 38'd0) begin bad++; $display("FAIL rst_rsp_fields got=%0h/%0b/%0d want=0", rsp_result, rsp_zero, rsp_rd); end
    #3 RESET = 1'b0;
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0b want=1", req_ready); end
  endtask

  task automatic test_single_op();
    rsp_ready = 1'b1;
    drive(3'b000, 1'b0, 32'd3, 32'd1, 5'd0, 5'd0, 5'd5);
    step();
    req_valid = 1'b0;
    total++; if ({alu_data1, alu_data2} !== {32'd3, 32'd1}) begin bad++; $display("FAIL single_alu_data got=%0d/%0d want=3/1", alu_data1, alu_data2); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", rsp_valid); end
    step();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%0b want=1", rsp_valid); end
    total++; if ({rsp_result, rsp_zero, rsp_rd} !== {32'd4, 1'b0, 5'd5}) begin bad++; $display("FAIL single_rsp got=%0d/%0b/%0d want=4/0/5", rsp_result, rsp_zero, rsp_rd); end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%0b want=0", rsp_valid); end
    total++; if (alu_data1 !== 32'd3) begin bad++; $display("FAIL single_alu_hold got=%0d want=3", alu_data1); end
  endtask

  task automatic test_zero_flag();
    drive(3'b000, 1'b1, 32'd3, 32'd3, 5'd0, 5'd0, 5'd6);
    step();
    req_valid = 1'b0;
    total++; if (alu_rotate !== 1'b1) begin bad++; $display("FAIL zero_rotate got=%0b want=1", alu_rotate); end
    step();
    total++; if ({rsp_valid, rsp_result, rsp_zero, rsp_rd} !== {1'b1, 32'd0, 1'b1, 5'd6}) begin bad++;
      $display("FAIL zero_rsp got=%0b/%0d/%0b/%0d want=1/0/1/6", rsp_valid, rsp_result, rsp_zero, rsp_rd); end
    step();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive(3'b000, 1'b0, 32'd10, 32'd1, 5'd0, 5'd0, 5'd1);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%0b want=1", req_ready); end
    step();
    drive(3'b000, 1'b0, 32'd20, 32'd1, 5'd0, 5'd0, 5'd2);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_b got=%0b want=1", req_ready); end
    step();
    drive(3'b000, 1'b0, 32'd30, 32'd1, 5'd0, 5'd0, 5'd3);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c1 got=%0b want=0", req_ready); end
    step();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%0b want=0", req_ready); end
    step();
    total++; if ({req_ready, rsp_valid, rsp_rd, rsp_result} !== {1'b0, 1'b1, 5'd1, 32'd11}) begin bad++;
      $display("FAIL bp_hold got=%0b/%0b/%0d/%0d want=0/1/1/11", req_ready, rsp_valid, rsp_rd, rsp_result); end
    rsp_ready = 1'b1;
    step();
    total++; if ({req_ready, rsp_valid, rsp_rd, rsp_result} !== {1'b1, 1'b1, 5'd2, 32'd21}) begin bad++;
      $display("FAIL bp_second got=%0b/%0b/%0d/%0d want=1/1/2/21", req_ready, rsp_valid, rsp_rd, rsp_result); end
    step();
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_gap got=%0b want=0", rsp_valid); end
    step();
    total++; if ({rsp_valid, rsp_rd, rsp_result} !== {1'b1, 5'd3, 32'd31}) begin bad++;
      $display("FAIL bp_third got=%0b/%0d/%0d want=1/3/31", rsp_valid, rsp_rd, rsp_result); end
    step();
  endtask

  task automatic test_push_pop();
    int sent = 0;
    int got = 0;
    logic acc;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (sent < 6) drive(3'b100, 1'b0, 32'h100, 32'(sent + 1), 5'd0, 5'd0, 5'(sent + 1));
      else req_valid = 1'b0;
      acc = req_valid & req_ready;
      if (rsp_valid) begin
        total++;
        if (rsp_rd !== 5'(got + 1) || rsp_result !== 32'(257 + got)) begin bad++;
          $display("FAIL stream_rsp got=%0d/%0h want=%0d/%0h", rsp_rd, rsp_result, got + 1, 257 + got); end
        got++;
      end
      step();
      if (acc) sent++;
    end
    req_valid = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL stream_count got=%0d want=6", got); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    drive(3'b000, 1'b0, 32'd5, 32'd6, 5'd0, 5'd0, 5'd9);
    step();
    drive(3'b000, 1'b0, 32'd7, 32'd8, 5'd0, 5'd0, 5'd10);
    step();
    req_valid = 1'b0;
    total++; if ({rsp_valid, alu_data1} !== {1'b1, 32'd7}) begin bad++; $display("FAIL mid_setup got=%0b/%0d want=1/7", rsp_valid, alu_data1); end
    #2 RESET = 1'b1;
    #1;
    total++; if ({rsp_valid, alu_data1, alu_data2, alu_select, alu_rotate} !== 69'd0) begin bad++;
      $display("FAIL mid_reset got=%0b/%0h/%0h/%0b/%0b want=0", rsp_valid, alu_data1, alu_data2, alu_select, alu_rotate); end
    #3 RESET = 1'b0;
    rsp_ready = 1'b1;
    step();
    total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL mid_after got=%0b/%0b want=1/0", req_ready, rsp_valid); end
    drive(3'b110, 1'b0, 32'h0F0, 32'h00F, 5'd0, 5'd0, 5'd4);
    step();
    req_valid = 1'b0;
    total++; if (alu_select !== 3'b110) begin bad++; $display("FAIL mid_sel got=%0b want=110", alu_select); end
    step();
    total++; if ({rsp_valid, rsp_result, rsp_rd} !== {1'b1, 32'h0FF, 5'd4}) begin bad++;
      $display("FAIL mid_first_op got=%0b/%0h/%0d want=1/ff/4", rsp_valid, rsp_result, rsp_rd); end
    step();
  endtask

  // Runs a dependent pair back-to-back and returns B's result.
  task automatic run_pair(input logic [4:0] a_rd, input logic [4:0] s1, input logic [4:0] s2,
                          input logic f7, input logic [31:0] b1, input logic [31:0] b2, output logic [31:0] res);
    rsp_ready = 1'b1;
    res = 32'hDEAD_BEEF;
    drive(3'b000, 1'b0, 32'd3, 32'd1, 5'd0, 5'd0, a_rd);
    step();
    drive(3'b000, f7, b1, b2, s1, s2, 5'd8);
    step();
    req_valid = 1'b0;
    step();
    if (rsp_valid && rsp_rd == 5'd8) res = rsp_result;
    step();
  endtask

  task automatic test_bypass();
    logic [31:0] r;
`ifdef ALU_BYPASS_EN
    localparam logic [31:0] EXP_RS1 = 32'd5;
    localparam logic [31:0] EXP_RS2 = 32'd6;
`else
    localparam logic [31:0] EXP_RS1 = 32'd100;
    localparam logic [31:0] EXP_RS2 = 32'hFFFF_FFD8;
`endif
    run_pair(5'd7, 5'd7, 5'd0, 1'b0, 32'd99, 32'd1, r);
    total++; if (r !== EXP_RS1) begin bad++; $display("FAIL byp_rs1 got=%0h want=%0h", r, EXP_RS1); end
    run_pair(5'd0, 5'd0, 5'd0, 1'b0, 32'd99, 32'd1, r);
    total++; if (r !== 32'd100) begin bad++; $display("FAIL byp_rd0 got=%0h want=64", r); end
    run_pair(5'd3, 5'd0, 5'd3, 1'b1, 32'd10, 32'd50, r);
    total++; if (r !== EXP_RS2) begin bad++; $display("FAIL byp_rs2 got=%0h want=%0h", r, EXP_RS2); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_zero_flag();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
